fft_vector_player: RTL
======================

# fft_vector_player

Synthesizable stimulus/response engine for the FFT datapath. It plays a stored block of complex input samples into the `fft` core one per clock. It captures the core's output after a fixed pipeline latency and compares it against a stored expected block. It then reports pass/fail, mismatch count and first failing index. It replaces the hand-timed simulation stimulus loop and allows the same vectors to run on silicon/FPGA bring-up.

## Interface
Parameters:
- DATA_W, 34: sample width; packed as {re_sign, re_int[7:0], re_frac[7:0], im_sign, im_int[7:0], im_frac[7:0]}. Each half is HALF_W = DATA_W/2, two's-complement style sign + magnitude bits treated as signed HALF_W value.
- DEPTH, 32: samples per block. Power of two, ≥ 2.
- ADDR_W, $clog2(DEPTH): memory address width.
- LATENCY, 1: cycles from a sample appearing on dut_in to its result appearing on dut_out. Range 0..15.
- TOL, 1: per-component tolerance in LSBs (used only with VP_TOLERANCE_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  memory write strobe.
- wr_sel  in  1  0 = stimulus memory, 1 = expected memory.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- start  in  1  one-cycle request to run a block.
- dut_in  out  DATA_W  registered sample to fft data_in.
- dut_in_vld  out  1  high while dut_in carries a valid sample.
- dut_out  in  DATA_W  fft data_out.
- busy  out  1  run in progress.
- done  out  1  level, high from end of run until next accepted start.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  ADDR_W+1  number of mismatching samples in last run.
- first_err_idx  out  ADDR_W  index of first mismatch; 0 if none.

## Operation
- Memories: two DEPTH×DATA_W arrays, not reset, contents survive reset. Writes accepted only when busy = 0; writes while busy are dropped.
- FSM states:
  - IDLE: waits for start.
  - PLAY: DEPTH cycles.
  - DRAIN: LATENCY cycles.
  - DONE: behaves as IDLE with done = 1.
- Transitions:
  - IDLE/DONE + start → PLAY. Clears done, err_count and first_err_idx.
  - PLAY, after sample DEPTH−1 is issued → DRAIN (or → DONE directly if LATENCY = 0).
  - DRAIN count exhausted → DONE.
- start while busy is ignored.
- PLAY: in play cycle k, dut_in = stim[k] and dut_in_vld = 1. DRAIN: dut_in = 0 and dut_in_vld = 0.
- Compare: result k is sampled from dut_out at the rising edge ending the cycle LATENCY after dut_in carried stim[k]. It is compared to exp[k].
- Mismatch handling: on each mismatch, err_count increments. On the first mismatch of a run, first_err_idx latches k.
- Exact mode compares all DATA_W bits.
- Simultaneous wr_en and start in IDLE: the write completes and the run reads the new value.

## Timing
- Reset values: dut_in = 0, dut_in_vld = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_err_idx = 0, FSM = IDLE.
- start sampled at edge T: busy = 1 and dut_in = stim[0] from T+1.
- Sample k is on dut_in during cycle T+1+k.
- Last compare occurs at the edge ending cycle T+DEPTH+LATENCY.
- done = 1, busy = 0 and pass are valid from the following cycle. Total run is DEPTH+LATENCY+1 cycles start-to-done.
- rst_n asserted mid-run: immediate abort to reset values. No done; memories retained.

## Configuration
- VP_TOLERANCE_EN defined: real and imaginary halves are each interpreted as signed HALF_W values. A sample matches iff |dut_re − exp_re| ≤ TOL and |dut_im − exp_im| ≤ TOL. The difference is computed in HALF_W+1 bits with no overflow.
- VP_TOLERANCE_EN undefined: bit-exact compare. TOL is unused, with no subtractor logic.

## Test plan
- Reset then idle: all outputs at reset values; start with empty memories → run completes, done = 1 after DEPTH+LATENCY+1 cycles.
- Identity loop (dut_out = dut_in delayed LATENCY = 1): stim = exp = k×0x1_0101 for k = 0..31 → pass = 1, err_count = 0, first_err_idx = 0.
- Corrupt exp[5] and exp[20] (flip bit 0) in exact mode → pass = 0, err_count = 2, first_err_idx = 5.
- With VP_TOLERANCE_EN, TOL = 1: exp[7] re off by +1 → pass = 1. exp[9] im off by −2 → err_count = 1, first_err_idx = 9.
- start pulses during busy and writes during busy → ignored. Memory readback on the next run shows the original data, with identical results.
- rst_n low at play cycle 10 → outputs return to reset values asynchronously. A subsequent start gives a complete correct run with the original memory contents.

Source files
------------

// File: rtl/fft_vector_player.sv
// Stimulus/response player for the fft core: streams a stored block, scores the result.
// Define VP_TOLERANCE_EN for a +/-TOL per-component compare instead of bit-exact.
module fft_vector_player #(
  parameter int DATA_W  = 34,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int LATENCY = 1,
  parameter int TOL     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic [DATA_W-1:0] dut_in,
  output logic              dut_in_vld,
  input  logic [DATA_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_idx
);

  localparam logic [3:0] DRAIN_LAST =
    4'(LATENCY > 0 ? LATENCY - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_PLAY, S_DRAIN, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] stim_mem [DEPTH];
  logic [DATA_W-1:0] exp_mem  [DEPTH];

  logic [ADDR_W-1:0] play_cnt;
  logic [ADDR_W-1:0] cmp_idx;
  logic [3:0]        drain_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] exp_data;
  logic              wr_ok;
  logic              start_ok;
  logic              last_smp;
  logic              cmp_vld;
  logic              mismatch;

  if (LATENCY < 0 || LATENCY > 15 || DEPTH < 2 || TOL < 0)
  begin : g_param_chk
    $error("fft_vector_player: parameter out of range");
  end

  assign wr_ok    = wr_en && !busy;
  assign start_ok = start && !busy;
  assign last_smp = (play_cnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      if (wr_sel) exp_mem[wr_addr]  <= wr_data;
      else        stim_mem[wr_addr] <= wr_data;
    end
  end

  // same-edge write to the first sample is forwarded into the run
  assign rd_addr = (state == S_PLAY) ?
                   play_cnt + 1'b1 : '0;
  assign rd_data = (wr_ok && !wr_sel &&
                    wr_addr == rd_addr) ?
                   wr_data : stim_mem[rd_addr];
  assign exp_data = exp_mem[cmp_idx];

  if (LATENCY == 0) begin : g_lat0
    assign cmp_vld = dut_in_vld;
  end else begin : g_latn
    logic [LATENCY-1:0] vld_sr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_sr <= '0;
      else vld_sr <= LATENCY'({vld_sr, dut_in_vld});
    end
    assign cmp_vld = vld_sr[LATENCY-1];
  end

`ifdef VP_TOLERANCE_EN
  localparam int HALF_W = DATA_W / 2;

  function automatic logic near(
    input logic [HALF_W-1:0] a,
    input logic [HALF_W-1:0] b
  );
    logic signed [HALF_W:0] d;
    logic [HALF_W:0]        m;
    d = $signed({a[HALF_W-1], a}) -
        $signed({b[HALF_W-1], b});
    m = d[HALF_W] ? unsigned'(-d) : unsigned'(d);
    return m <= (HALF_W + 1)'(TOL);
  endfunction

  assign mismatch = !(
    near(dut_out[2*HALF_W-1:HALF_W],
         exp_data[2*HALF_W-1:HALF_W]) &&
    near(dut_out[HALF_W-1:0],
         exp_data[HALF_W-1:0]));
`else
  assign mismatch = (dut_out != exp_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_FIN:
        if (start) state_nxt = S_PLAY;
      S_PLAY:
        if (last_smp)
          state_nxt = (LATENCY == 0) ? S_FIN : S_DRAIN;
      S_DRAIN:
        if (drain_cnt == '0) state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_PLAY) || (state == S_DRAIN);
    done = (state == S_FIN);
  end

  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in        <= '0;
      dut_in_vld    <= 1'b0;
      play_cnt      <= '0;
      drain_cnt     <= '0;
      cmp_idx       <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ?
                   drain_cnt - 1'b1 : DRAIN_LAST;
      if (start_ok) begin
        play_cnt      <= '0;
        dut_in        <= rd_data;
        dut_in_vld    <= 1'b1;
        cmp_idx       <= '0;
        err_count     <= '0;
        first_err_idx <= '0;
      end else begin
        if (state == S_PLAY) begin
          if (last_smp) begin
            dut_in     <= '0;
            dut_in_vld <= 1'b0;
          end else begin
            play_cnt <= play_cnt + 1'b1;
            dut_in   <= rd_data;
          end
        end
        if (cmp_vld) begin
          cmp_idx <= cmp_idx + 1'b1;
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0)
              first_err_idx <= cmp_idx;
          end
        end
      end
    end
  end

endmodule
